// File: rtl/my_dmux_n_way_buf.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : my_dmux_n_way_buf                                                 |
// | Routes one valid/ready input stream to one of 2**SEL_W buffered channels,  |
// | each with a one-entry holding register. Define DMUX_BCAST_EN to add the    |
// | in_bcast input that loads every channel at once.                           |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module my_dmux_n_way_buf #(
  parameter int WIDTH = 16,
  parameter int SEL_W = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [WIDTH-1:0]            in_data,
  input  logic [SEL_W-1:0]            in_sel,
`ifdef DMUX_BCAST_EN
  input  logic                        in_bcast,
`endif
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic [(2**SEL_W)*WIDTH-1:0] out_data,
  output logic [(2**SEL_W)-1:0]       out_valid,
  input  logic [(2**SEL_W)-1:0]       out_ready
);

  localparam int N = 2**SEL_W;

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  logic [N-1:0] w_slot_free;
  logic         w_bcast;
  logic         w_acc;

`ifdef DMUX_BCAST_EN
  assign w_bcast = in_bcast;
`else
  assign w_bcast = 1'b0;
`endif

  // A slot can take a beat if it is empty or being drained this same cycle.
  assign w_slot_free = ~out_valid | out_ready;

  always_comb begin
    in_ready = 1'b0;
    if (!reset) begin
      in_ready = w_bcast ? (&w_slot_free) : w_slot_free[in_sel];
    end
  end

  assign w_acc = in_valid & in_ready;

  for (genvar k = 0; k < N; k++) begin : g_ch
    logic [0:0]       state_q;
    logic [0:0]       state_d;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;
    logic             w_ld;
    logic             w_dr;
    logic             w_full;

    assign w_ld = w_acc & (w_bcast | (in_sel == SEL_W'(k)));
    assign w_dr = w_full & out_ready[k];

    always_ff @(posedge clk) begin
      if (reset) begin
        state_q <= ST_EMPTY;
        data_q  <= '0;
      end else begin
        state_q <= state_d;
        data_q  <= data_d;
      end
    end

    always_comb begin
      state_d = state_q;
      data_d  = data_q;
      case (state_q)
        ST_EMPTY: if (w_ld) state_d = ST_FULL;
        ST_FULL:  if (w_dr && !w_ld) state_d = ST_EMPTY;
        default:  state_d = ST_EMPTY;
      endcase
      if (w_ld) begin
        data_d = in_data;
      end
    end

    always_comb begin
      w_full = (state_q == ST_FULL);
    end

    assign out_valid[k]                 = w_full;
    assign out_data[k*WIDTH +: WIDTH]   = data_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_my_dmux_n_way_buf.sv
`default_nettype none
// Bench for my_dmux_n_way_buf: directed stimulus with a per-channel expected-data
// queue that is pushed on accept and popped on drain, checked every negedge.
module tb_my_dmux_n_way_buf;

  localparam int WIDTH = 16;
  localparam int SEL_W = 2;
  localparam int N     = 2**SEL_W;

  logic               clk;
  logic               reset;
  logic [WIDTH-1:0]   in_data;
  logic [SEL_W-1:0]   in_sel;
  logic               in_bcast;
  logic               in_valid;
  logic               in_ready;
  logic [N*WIDTH-1:0] out_data;
  logic [N-1:0]       out_valid;
  logic [N-1:0]       out_ready;

  int total = 0;
  int bad   = 0;

  logic [WIDTH-1:0] sb_q [N][$];
  logic [WIDTH-1:0] last_q [N];

  my_dmux_n_way_buf #(.WIDTH(WIDTH), .SEL_W(SEL_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_sel    (in_sel),
`ifdef DMUX_BCAST_EN
    .in_bcast  (in_bcast),
`endif
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Scoreboard/monitor: sampled mid-cycle, ahead of the edge that commits transfers.
  always @(negedge clk) begin
    logic exp_rdy;
    logic bc;
    logic [WIDTH-1:0] popped;
    bc = 1'b0;
`ifdef DMUX_BCAST_EN
    bc = in_bcast;
`endif
    if (reset) begin
      check("in_ready_in_reset", {31'b0, in_ready}, 32'd0);
      for (int k = 0; k < N; k++) begin
        sb_q[k].delete();
        last_q[k] = '0;
      end
    end else begin
      if (bc) begin
        exp_rdy = 1'b1;
        for (int k = 0; k < N; k++)
          if (sb_q[k].size() != 0 && !out_ready[k]) exp_rdy = 1'b0;
      end else begin
        exp_rdy = (sb_q[in_sel].size() == 0) || out_ready[in_sel];
      end
      check("in_ready", {31'b0, in_ready}, {31'b0, exp_rdy});
      for (int k = 0; k < N; k++) begin
        check($sformatf("out_valid[%0d]", k), {31'b0, out_valid[k]},
              {31'b0, (sb_q[k].size() != 0)});
        check($sformatf("out_data[%0d]", k), {16'b0, out_data[k*WIDTH +: WIDTH]},
              {16'b0, last_q[k]});
        if (sb_q[k].size() != 0 && out_ready[k]) begin
          popped = sb_q[k].pop_front();
          check($sformatf("drain_data[%0d]", k), {16'b0, out_data[k*WIDTH +: WIDTH]},
                {16'b0, popped});
        end
      end
      if (in_valid && exp_rdy) begin
        for (int k = 0; k < N; k++) begin
          if (bc || in_sel == SEL_W'(k)) begin
            sb_q[k].push_back(in_data);
            last_q[k] = in_data;
          end
        end
      end
    end
  end

  task automatic drive(input logic v, input logic [SEL_W-1:0] s, input logic [WIDTH-1:0] d,
                       input logic [N-1:0] rdy, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
      in_valid  = v;
      in_sel    = s;
      in_data   = d;
      out_ready = rdy;
    end
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_sel    = '0;
    in_data   = '0;
    in_bcast  = 1'b0;
    out_ready = '1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // 1: one beat to each channel on consecutive cycles
    drive(1'b1, 2'd0, 16'hA001, 4'b1111, 1);
    drive(1'b1, 2'd1, 16'hB002, 4'b1111, 1);
    drive(1'b1, 2'd2, 16'hC003, 4'b1111, 1);
    drive(1'b1, 2'd3, 16'hD004, 4'b1111, 1);
    drive(1'b0, 2'd0, 16'h0000, 4'b1111, 2);

    // 2/3: stall ch2 full, ch1 still flows, ch2 refill without bubble
    drive(1'b1, 2'd2, 16'h1111, 4'b1011, 1);
    drive(1'b1, 2'd1, 16'h3333, 4'b1011, 1);
    drive(1'b1, 2'd2, 16'h2222, 4'b1011, 3);
    drive(1'b1, 2'd2, 16'h2222, 4'b1111, 1);
    drive(1'b0, 2'd0, 16'h0000, 4'b1111, 2);

    // 4: sustained stream into ch0
    for (int i = 0; i < 8; i++)
      drive(1'b1, 2'd0, 16'h0100 + 16'(i), 4'b1111, 1);
    drive(1'b0, 2'd0, 16'h0000, 4'b1111, 2);

    // 5: fill ch1 and ch3 then reset while a beat is offered
    drive(1'b1, 2'd1, 16'h7777, 4'b0000, 1);
    drive(1'b1, 2'd3, 16'h8888, 4'b0000, 1);
    drive(1'b0, 2'd0, 16'h0000, 4'b0000, 1);
    @(posedge clk);
    #1;
    reset    = 1'b1;
    in_valid = 1'b1;
    in_sel   = 2'd0;
    in_data  = 16'h9999;
    @(posedge clk);
    #1;
    reset    = 1'b0;
    in_valid = 1'b0;
    drive(1'b0, 2'd0, 16'h0000, 4'b1111, 2);

`ifdef DMUX_BCAST_EN
    // 6: broadcast waits for the stalled ch0, then loads all channels
    drive(1'b1, 2'd0, 16'h4444, 4'b1110, 1);
    @(posedge clk);
    #1;
    in_bcast = 1'b1;
    in_valid = 1'b1;
    in_sel   = 2'd3;
    in_data  = 16'h5A5A;
    @(posedge clk);
    #1;
    out_ready = 4'b1111;
    @(posedge clk);
    #1;
    in_bcast = 1'b0;
    in_valid = 1'b0;
    drive(1'b0, 2'd0, 16'h0000, 4'b1111, 2);
`endif

    drive(1'b0, 2'd0, 16'h0000, 4'b1111, 2);
    @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
